// File: rtl/conv_pkg.sv
// Shared definitions for the K=3 rate-1/2 convolutional code.
// Used by the encoder and by the Viterbi decoder blocks (BMC/ACS).
package conv_pkg;

  // Constraint length; the encoder state register holds K-1 past bits.
  localparam int K = 3;

  // Generators. The MSB taps the current input bit and the LSB the oldest bit.
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  // Coded pair as {G0 bit, G1 bit}. This matches the decoder's rx_pair[1:0].
  typedef logic [1:0] pair_t;

  // Encoder control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_e;

  // Modulo-2 sum of the window bits selected by generator g
  function automatic logic parity(input logic [K-1:0] w, input logic [K-1:0] g);
    return ^(w & g);
  endfunction

endpackage

// File: rtl/conv_enc_parity.sv
// Combinational code generator: maps one K-bit window to a coded pair.
// The window is {current input, newest past bit, ..., oldest past bit}.
module conv_enc_parity
  import conv_pkg::*;
#(
  parameter logic [K-1:0] GEN0 = G0,
  parameter logic [K-1:0] GEN1 = G1
) (
  input  logic [K-1:0] window_i,
  output pair_t        pair_o
);

  // pair_o[1] comes from GEN0 and pair_o[0] from GEN1
  assign pair_o = {parity(window_i, GEN0), parity(window_i, GEN1)};

endmodule

// File: rtl/conv_encoder_k3.sv
// Rate-1/2 K=3 convolutional encoder with automatic zero-tail flush.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both 1. A valid is never withdrawn and its payload never
// changes until that transfer. in_ready may depend combinationally on out_ready.
//
// Every accepted data bit loads one coded pair into a single output register.
// The pair is visible one cycle after the accepting edge. After the bit marked
// in_last, the encoder inserts K-1 tail pairs computed with a zero input. These
// return the shift register to state 0. The final tail pair carries out_last.
//
// Optional build macro CONV_ENC_ERR_INJECT_EN adds an err_mask input. err_mask
// is XORed into each pair as it is loaded, to inject channel errors. It never
// touches the shift register.
module conv_encoder_k3
  import conv_pkg::*;
#(
  parameter logic [K-1:0] GEN0 = G0,
  parameter logic [K-1:0] GEN1 = G1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output pair_t      out_pair,
  output logic       out_last,
  output logic       out_tail,
`ifdef CONV_ENC_ERR_INJECT_EN
  input  logic [1:0] err_mask,
`endif
  output enc_state_e dbg_state
);

  // The tail counter runs from 0 to K-2
  localparam int                CW        = (K > 2) ? $clog2(K) : 1;
  localparam logic [CW-1:0]     TAIL_LAST = CW'(K - 2);

  enc_state_e     state_q;
  logic [CW-1:0]  tail_cnt_q;
  logic [K-2:0]   sr_q;        // sr_q[K-2] holds the newest past bit
  logic           out_valid_q;
  pair_t          out_pair_q;
  logic           out_last_q;
  logic           out_tail_q;

  logic           ld;          // output register can take a new pair this cycle
  logic           accept;      // data bit transferred this cycle
  logic           tail_ld;     // tail pair loaded this cycle
  logic           load;        // any pair loaded this cycle
  logic           last_tail;   // this tail pair is the final one of the frame
  logic           in_eff;      // input bit fed to the code (zero during the tail)
  logic [K-1:0]   window;
  pair_t          code_pair;
  pair_t          load_pair;
  logic [K-2:0]   sr_d;

  // The output register may load when it is empty or is being drained now
  assign ld        = !out_valid_q || out_ready;
  assign in_ready  = (state_q != TAIL) && ld;
  assign accept    = in_valid && in_ready;
  assign tail_ld   = (state_q == TAIL) && ld;
  assign load      = accept || tail_ld;
  assign last_tail = tail_ld && (tail_cnt_q == TAIL_LAST);
  assign in_eff    = accept ? in_bit : 1'b0;
  assign window    = {in_eff, sr_q};

  // The newest bit enters at the top and the oldest bit falls off the bottom
  generate
    if (K > 2) begin : g_sr_shift
      assign sr_d = {in_eff, sr_q[K-2:1]};
    end else begin : g_sr_single
      assign sr_d = in_eff;
    end
  endgenerate

  conv_enc_parity #(
    .GEN0 (GEN0),
    .GEN1 (GEN1)
  ) u_parity (
    .window_i (window),
    .pair_o   (code_pair)
  );

`ifdef CONV_ENC_ERR_INJECT_EN
  // The injected error corrupts only the transmitted pair
  assign load_pair = code_pair ^ err_mask;
`else
  assign load_pair = code_pair;
`endif

  // Frame control, shift register and the registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tail_cnt_q  <= '0;
      sr_q        <= '0;
      out_valid_q <= 1'b0;
      out_pair_q  <= 2'b00;
      out_last_q  <= 1'b0;
      out_tail_q  <= 1'b0;
    end else begin
      // Output register: load a new pair, or empty it once it has been taken
      if (load) begin
        out_valid_q <= 1'b1;
        out_pair_q  <= load_pair;
        out_tail_q  <= tail_ld;
        out_last_q  <= last_tail;
        sr_q        <= sr_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= in_last ? TAIL : DATA;
            tail_cnt_q <= '0;
          end
        end
        DATA: begin
          if (accept && in_last) begin
            state_q    <= TAIL;
            tail_cnt_q <= '0;
          end
        end
        TAIL: begin
          if (tail_ld) begin
            if (last_tail) begin
              state_q    <= IDLE;
              tail_cnt_q <= '0;
            end else begin
              tail_cnt_q <= tail_cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          tail_cnt_q <= '0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_pair  = out_pair_q;
  assign out_last  = out_last_q;
  assign out_tail  = out_tail_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Testbench for conv_encoder_k3. Expected pairs come from a convolution
// computed over whole frames, not from a model of the register-level design.
`timescale 1ns/1ps
module tb_conv_encoder_k3;
  import conv_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_bit, in_last, out_ready;
  logic       in_ready, out_valid, out_last, out_tail;
  pair_t      out_pair;
  enc_state_e dbg_state;
`ifdef CONV_ENC_ERR_INJECT_EN
  logic [1:0] err_mask;
`endif

  always #5 clk = ~clk;

  conv_encoder_k3 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pair  (out_pair),
    .out_last  (out_last),
    .out_tail  (out_tail),
`ifdef CONV_ENC_ERR_INJECT_EN
    .err_mask  (err_mask),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Each entry is {pair[1:0], tail, last}
  logic [3:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  bit rand_bp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: pair i is the mod-2 convolution of the zero-padded frame with each generator
  task automatic model_frame(input logic fb[$], input int mi, input logic [1:0] mv);
    logic [K-1:0] g0, g1;
    int n;
    g0 = G0;
    g1 = G1;
    n  = fb.size();
    for (int i = 0; i < n + K - 1; i++) begin
      int s0, s1;
      logic [1:0] p;
      s0 = 0;
      s1 = 0;
      for (int j = 0; j < K; j++) begin
        int idx, b;
        idx = i - j;
        b   = (idx >= 0 && idx < n) ? int'(fb[idx]) : 0;
        s0 += b * int'(g0[K-1-j]);
        s1 += b * int'(g1[K-1-j]);
      end
      p = {s0[0], s1[0]};
      if (i == mi) p = p ^ mv;
      exp_q.push_back({p, (i >= n), (i == n + K - 2)});
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid and ready are both 1
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [3:0] e;
      if (exp_q.size() == 0) begin
        check("unexpected_pair", {out_pair, out_tail, out_last}, 4'hx);
      end else begin
        e = exp_q.pop_front();
        check("pair", out_pair, e[3:2]);
        check("tail_flag", out_tail, e[1]);
        check("last_flag", out_last, e[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step_ready();
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_bit(input logic b, input logic last, input logic [1:0] mask);
    bit acc;
    int guard;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = last;
`ifdef CONV_ENC_ERR_INJECT_EN
    err_mask = mask;
`else
    if (mask != 2'b00) $display("note: err_mask ignored in this build");
`endif
    acc   = 0;
    guard = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      step_ready();
      guard++;
    end
    check("accept_timeout", acc, 1'b1);
    in_valid = 1'b0;
`ifdef CONV_ENC_ERR_INJECT_EN
    err_mask = 2'b00;
`endif
  endtask

  // Idle cycles with a stray in_last, which must be ignored while in_valid=0
  task automatic gap(input int n);
    in_valid = 1'b0;
    in_last  = 1'b1;
    in_bit   = 1'($urandom_range(0, 1));
    repeat (n) begin
      @(posedge clk);
      #1;
      step_ready();
    end
    in_last = 1'b0;
  endtask

  task automatic send_frame(input logic fb[$], input bit gaps);
    for (int i = 0; i < fb.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
      send_bit(fb[i], (i == fb.size() - 1), 2'b00);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clk);
      #1;
      step_ready();
      guard++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic fb[$];
    bit found;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
`ifdef CONV_ENC_ERR_INJECT_EN
    err_mask  = 2'b00;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pair", out_pair, 2'b00);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_tail", out_tail, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", in_ready, 1'b1);

    // Test 1: bits 1,0,1,1(last) -> 11,10,00,01 then tail 01,11
    fb = '{1'b1, 1'b0, 1'b1, 1'b1};
    model_frame(fb, -1, 2'b00);
    send_frame(fb, 0);
    drain();

    // Test 2: single-bit frame; no input is taken while the tail is flushed
    fb = '{1'b1};
    model_frame(fb, -1, 2'b00);
    send_bit(1'b1, 1'b1, 2'b00);
    repeat (2) begin
      @(negedge clk);
      check("tail_in_ready", in_ready, 1'b0);
      check("tail_state", dbg_state, TAIL);
    end
    @(negedge clk);
    check("post_tail_in_ready", in_ready, 1'b1);
    drain();

    // Test 3: backpressure for 5 cycles mid-frame
    fb = '{1'b1, 1'b0, 1'b1, 1'b1};
    model_frame(fb, -1, 2'b00);
    send_bit(1'b1, 1'b0, 2'b00);
    send_bit(1'b0, 1'b0, 2'b00);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    in_last   = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_pair_held", out_pair, exp_q[0][3:2]);
      check("bp_tail_held", out_tail, exp_q[0][1]);
      check("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_bit(1'b1, 1'b0, 2'b00);
    send_bit(1'b1, 1'b1, 2'b00);
    drain();

    // Test 4: back-to-back frames; frame 2 starts as the final tail pair is taken
    fb = '{1'b1, 1'b1, 1'b0};
    model_frame(fb, -1, 2'b00);
    fb = '{1'b1, 1'b0};
    model_frame(fb, -1, 2'b00);
    send_bit(1'b1, 1'b0, 2'b00);
    send_bit(1'b1, 1'b0, 2'b00);
    send_bit(1'b0, 1'b1, 2'b00);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    in_last  = 1'b0;
    found    = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (out_valid && out_last) found = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("b2b_last_seen", found, 1'b1);
    check("b2b_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    send_bit(1'b0, 1'b1, 2'b00);
    drain();

    // Test 5: reset during the tail aborts the frame
    fb = '{1'b1};
    model_frame(fb, -1, 2'b00);
    send_bit(1'b1, 1'b1, 2'b00);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_out_pair", out_pair, 2'b00);
    check("abort_out_last", out_last, 1'b0);
    check("abort_out_tail", out_tail, 1'b0);
    check("abort_state", dbg_state, IDLE);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fb = '{1'b1};
    model_frame(fb, -1, 2'b00);
    send_bit(1'b1, 1'b1, 2'b00);
    drain();

`ifdef CONV_ENC_ERR_INJECT_EN
    // Test 6: corrupt the 2nd pair of test 1 (10 -> 00)
    fb = '{1'b1, 1'b0, 1'b1, 1'b1};
    model_frame(fb, 1, 2'b10);
    send_bit(1'b1, 1'b0, 2'b00);
    send_bit(1'b0, 1'b0, 2'b10);
    send_bit(1'b1, 1'b0, 2'b00);
    send_bit(1'b1, 1'b1, 2'b00);
    drain();
`endif

    // Random frames with random backpressure and idle gaps
    rand_bp = 1;
    for (int f = 0; f < 12; f++) begin
      int n;
      n = $urandom_range(1, 16);
      fb.delete();
      for (int i = 0; i < n; i++) fb.push_back(1'($urandom_range(0, 1)));
      model_frame(fb, -1, 2'b00);
      send_frame(fb, 1);
    end
    drain();
    rand_bp   = 0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("final_out_valid", out_valid, 1'b0);
    check("final_state", dbg_state, IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
